i2s_rx_channel: RTL and testbench
=================================

Name: i2s_rx_channel

Overview:
- Receive-side I2S channel, clocked by the bit clock sck_i.
- Deserialises one or two serial data pins, aligned to word-select (WS) edges, into right-aligned 32-bit words.
- Pushes the words into the uDMA RX FIFO through a valid/ready handshake.
- Counterpart of the I2S TX channel; uses the same cfg_* register semantics so one register file drives both directions.

Parameters:
- none. Data path fixed at 32 bits; word counter 3 bits.

Ports:
- sck_i  in  1  I2S bit clock; all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- i2s_ch0_i  in  1  serial data, channel 0
- i2s_ch1_i  in  1  serial data, channel 1 (used only when cfg_2ch_i=1)
- i2s_ws_i  in  1  word select
- fifo_data_o  out  32  received word, right-aligned
- fifo_data_valid_o  out  1  fifo_data_o valid
- fifo_data_ready_i  in  1  FIFO accepts word
- fifo_err_o  out  1  one-cycle overflow pulse
- cfg_en_i  in  1  channel enable
- cfg_2ch_i  in  1  1 = sample both pins
- cfg_wlen_i  in  5  word length minus 1 (bits = wlen+1; 0 unsupported)
- cfg_wnum_i  in  3  words per WS phase minus 1
- cfg_lsb_first_i  in  1  1 = LSB received first

Behaviour:
Reset:
- state IDLE; shift registers, output register, shadow, counters, r_ws_q all 0.
- fifo_data_o=0, fifo_data_valid_o=0, fifo_err_o=0.

WS edge detection:
- r_ws_q <= i2s_ws_i every cycle.
- ws_edge = i2s_ws_i ^ r_ws_q.

State machine:
- IDLE: leave to WAIT when cfg_en_i=1.
- WAIT: on ws_edge go to RUNNING; bit count and word count set to 0.
- RUNNING: sample pins every cycle.
  - Word is done when r_count_bit == cfg_wlen_i.
  - On word done: bit count -> 0, word count +1.
  - If r_count_word == cfg_wnum_i at word done, go to SKIP.
  - Otherwise continue with the next word (TDM) on the next cycle.
- SKIP: ignore pins; on ws_edge go to RUNNING with counters cleared.
- cfg_en_i=0 in any state: next cycle IDLE, counters cleared, partial words discarded, fifo_data_valid_o and shadow cleared.

First-bit timing:
- The first data bit is sampled on the rising edge after the edge that detected ws_edge (standard I2S one-bit delay).

Assembly:
- MSB-first: sr <= {sr[30:0], pin}.
- LSB-first: sr[r_count_bit] <= pin.
- Both modes: sr cleared at word start; result occupies bits [wlen:0]; upper bits 0.

Output handshake:
- The word is loaded into the output register on the same edge that samples its last bit; fifo_data_valid_o goes high after that edge.
- Valid is held, with data stable, until the cycle where valid & ready; it drops the next cycle unless the shadow is pending.
- 2ch mode: ch0 word goes to the output register, ch1 word to the shadow (pending=1).
  - The shadow moves to the output register on the cycle after the ch0 word is accepted.
  - Order is always ch0, ch1.

Overflow:
- Condition: at word done, the output register is still valid and not being accepted that cycle, or the shadow is pending.
- Action: all new word(s) dropped, held data untouched, fifo_err_o=1 for one cycle.

WS resynchronisation:
- A ws_edge in RUNNING mid-word (bit count != 0) discards the partial word, clears the counters and restarts at bit 0.
- No error is flagged for this case.

Optional Feature:
- Macro: I2S_RX_SIGN_EXT_EN.
- Defined: the completed word has bits [31:wlen+1] filled with bit [wlen] (two's-complement sign extension) before loading the output register/shadow.
- Undefined: upper bits are zero.

Test Plan:
1. Mono, MSB-first: wlen=15, wnum=0, 2ch=0, ready=1; after a WS edge send 0xA5C3 on ch0 -> one push 0x0000A5C3; pins ignored until the next WS edge; fifo_err_o never asserted.
2. 2ch, LSB-first: wlen=31; ch0 word 0x12345678, ch1 word 0x9ABCDEF0 -> pushes 0x12345678 then 0x9ABCDEF0 on consecutive ready cycles.
3. TDM: wnum=3, wlen=7, ch0 bytes 0x01,0x02,0x03,0x04 in one WS phase -> four pushes in order; the following bits stay in SKIP until the WS edge.
4. Overflow: ready=0, two 16-bit words -> first word held valid; second word dropped with fifo_err_o high for exactly one cycle; raising ready delivers the first word only.
5. WS toggled after 5 bits of a 16-bit word -> nothing pushed; a clean word received next is correct. Then drop cfg_en_i mid-word -> valid=0 next cycle, state IDLE.
6. With I2S_RX_SIGN_EXT_EN: wlen=15, word 0x8001 -> fifo_data_o=0xFFFF8001. Without the macro -> 0x00008001.

Source files
------------

// File: rtl/i2s_rx_channel.sv
// I2S receive channel: deserialises one or two data pins into right-aligned 32-bit words for the uDMA RX FIFO.
// Optional build macro I2S_RX_SIGN_EXT_EN sign-extends each completed word from bit [wlen].
module i2s_rx_channel (
    input  logic        sck_i,
    input  logic        rstn_i,
    input  logic        i2s_ch0_i,
    input  logic        i2s_ch1_i,
    input  logic        i2s_ws_i,
    output logic [31:0] fifo_data_o,
    output logic        fifo_data_valid_o,
    input  logic        fifo_data_ready_i,
    output logic        fifo_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_wlen_i,
    input  logic [2:0]  cfg_wnum_i,
    input  logic        cfg_lsb_first_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        ws_q_r;
    logic        ws_edge_s;
    logic [4:0]  count_bit_r;
    logic [2:0]  count_word_r;
    logic [31:0] sr0_r;
    logic [31:0] sr1_r;
    logic [31:0] sr0_next_s;
    logic [31:0] sr1_next_s;
    logic [31:0] word0_s;
    logic [31:0] word1_s;
    logic [31:0] data_r;
    logic [31:0] shadow_r;
    logic        valid_r;
    logic        shadow_pend_r;
    logic        err_r;
    logic        sample_s;
    logic        word_done_s;
    logic        restart_s;
    logic        accept_s;
    logic        overflow_s;

    function automatic logic [31:0] shift_in(input logic [31:0] sr, input logic pin,
                                             input logic lsb_first, input logic [4:0] idx);
        logic [31:0] res;
        res = sr;
        if (lsb_first) begin
            res[idx] = pin;
        end else begin
            res = {sr[30:0], pin};
        end
        return res;
    endfunction

    function automatic logic [31:0] finish_word(input logic [31:0] w, input logic [4:0] wlen);
        logic [31:0] keep;
        keep = 32'hFFFF_FFFF >> (5'd31 - wlen);
`ifdef I2S_RX_SIGN_EXT_EN
        if (w[wlen]) begin
            return w | ~keep;
        end else begin
            return w & keep;
        end
`else
        return w & keep;
`endif
    endfunction

    assign ws_edge_s   = i2s_ws_i ^ ws_q_r;
    assign sr0_next_s  = shift_in(sr0_r, i2s_ch0_i, cfg_lsb_first_i, count_bit_r);
    assign sr1_next_s  = shift_in(sr1_r, i2s_ch1_i, cfg_lsb_first_i, count_bit_r);
    assign word0_s     = finish_word(sr0_next_s, cfg_wlen_i);
    assign word1_s     = finish_word(sr1_next_s, cfg_wlen_i);
    assign accept_s    = valid_r & fifo_data_ready_i;
    assign overflow_s  = word_done_s & ((valid_r & ~fifo_data_ready_i) | shadow_pend_r);

    // State register.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes; a word completing on the WS edge itself is kept.
    always_comb begin
        state_next_s = state_r;
        sample_s     = 1'b0;
        word_done_s  = 1'b0;
        restart_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg_en_i) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT, ST_SKIP: begin
                if (ws_edge_s) begin
                    state_next_s = ST_RUN;
                    restart_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_RUN: begin
                if (count_bit_r == cfg_wlen_i) begin
                    sample_s    = 1'b1;
                    word_done_s = 1'b1;
                    if (ws_edge_s) begin
                        restart_s    = 1'b1;
                        state_next_s = ST_RUN;
                    end else if (count_word_r == cfg_wnum_i) begin
                        state_next_s = ST_SKIP;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else if (ws_edge_s) begin
                    restart_s    = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    sample_s     = 1'b1;
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (!cfg_en_i) begin
            state_next_s = ST_IDLE;
            sample_s     = 1'b0;
            word_done_s  = 1'b0;
            restart_s    = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // WS history, bit/word counters and shift registers.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ws_q_r       <= 1'b0;
            count_bit_r  <= 5'd0;
            count_word_r <= 3'd0;
            sr0_r        <= 32'd0;
            sr1_r        <= 32'd0;
        end else begin
            ws_q_r <= i2s_ws_i;
            if (!cfg_en_i) begin
                count_bit_r  <= 5'd0;
                count_word_r <= 3'd0;
                sr0_r        <= 32'd0;
                sr1_r        <= 32'd0;
            end else if (word_done_s) begin
                count_bit_r  <= 5'd0;
                count_word_r <= restart_s ? 3'd0 : (count_word_r + 3'd1);
                sr0_r        <= 32'd0;
                sr1_r        <= 32'd0;
            end else if (restart_s) begin
                count_bit_r  <= 5'd0;
                count_word_r <= 3'd0;
                sr0_r        <= 32'd0;
                sr1_r        <= 32'd0;
            end else if (sample_s) begin
                count_bit_r  <= count_bit_r + 5'd1;
                sr0_r        <= sr0_next_s;
                sr1_r        <= sr1_next_s;
            end else begin
                count_bit_r  <= count_bit_r;
            end
        end
    end

    // Output register, ch1 shadow and overflow pulse; held data is never overwritten on overflow.
    always_ff @(posedge sck_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_r        <= 32'd0;
            shadow_r      <= 32'd0;
            valid_r       <= 1'b0;
            shadow_pend_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            err_r <= overflow_s;
            if (!cfg_en_i) begin
                valid_r       <= 1'b0;
                shadow_pend_r <= 1'b0;
                shadow_r      <= 32'd0;
            end else if (word_done_s && !overflow_s) begin
                data_r  <= word0_s;
                valid_r <= 1'b1;
                if (cfg_2ch_i) begin
                    shadow_r      <= word1_s;
                    shadow_pend_r <= 1'b1;
                end else begin
                    shadow_pend_r <= 1'b0;
                end
            end else if (accept_s && shadow_pend_r) begin
                data_r        <= shadow_r;
                shadow_pend_r <= 1'b0;
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign fifo_data_o       = data_r;
    assign fifo_data_valid_o = valid_r;
    assign fifo_err_o        = err_r;

endmodule

// File: tb/tb_i2s_rx_channel.sv
// Scoreboard bench for i2s_rx_channel: expected words are queued as frames are driven and
// compared as the channel hands them to the FIFO.
module tb_i2s_rx_channel;

    logic        sck_i = 1'b0;
    logic        rstn_i;
    logic        i2s_ch0_i, i2s_ch1_i, i2s_ws_i;
    logic [31:0] fifo_data_o;
    logic        fifo_data_valid_o, fifo_data_ready_i, fifo_err_o;
    logic        cfg_en_i, cfg_2ch_i, cfg_lsb_first_i;
    logic [4:0]  cfg_wlen_i;
    logic [2:0]  cfg_wnum_i;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          err_seen = 0;
    int          err_base;
    int          pop_cyc[$];
    logic [31:0] exp_q[$];

    i2s_rx_channel dut (
        .sck_i             (sck_i),
        .rstn_i            (rstn_i),
        .i2s_ch0_i         (i2s_ch0_i),
        .i2s_ch1_i         (i2s_ch1_i),
        .i2s_ws_i          (i2s_ws_i),
        .fifo_data_o       (fifo_data_o),
        .fifo_data_valid_o (fifo_data_valid_o),
        .fifo_data_ready_i (fifo_data_ready_i),
        .fifo_err_o        (fifo_err_o),
        .cfg_en_i          (cfg_en_i),
        .cfg_2ch_i         (cfg_2ch_i),
        .cfg_wlen_i        (cfg_wlen_i),
        .cfg_wnum_i        (cfg_wnum_i),
        .cfg_lsb_first_i   (cfg_lsb_first_i)
    );

    always #5 sck_i = ~sck_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected FIFO word for a transmitted value of wlen+1 bits.
    function automatic logic [31:0] exp_word(input logic [31:0] w, input int wlen);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i <= wlen) r[i] = w[i];
`ifdef I2S_RX_SIGN_EXT_EN
            else r[i] = w[wlen];
`endif
        end
        return r;
    endfunction

    function automatic logic bit_of(input logic [31:0] w, input int k, input int wlen, input logic lsb);
        return lsb ? w[k] : w[wlen - k];
    endfunction

    task automatic tick(input logic ws, input logic d0, input logic d1);
        i2s_ws_i  = ws;
        i2s_ch0_i = d0;
        i2s_ch1_i = d1;
        @(posedge sck_i);
        #1;
    endtask

    task automatic send_word(input logic ws, input logic [31:0] w0, input logic [31:0] w1);
        int wl;
        wl = int'(cfg_wlen_i);
        for (int k = 0; k <= wl; k++)
            tick(ws, bit_of(w0, k, wl, cfg_lsb_first_i), bit_of(w1, k, wl, cfg_lsb_first_i));
    endtask

    task automatic noise(input logic ws, input int n);
        for (int k = 0; k < n; k++) tick(ws, 1'($urandom), 1'($urandom));
    endtask

    // Monitor: a handshake seen here completes on the following rising edge.
    initial begin
        forever begin
            @(negedge sck_i);
            cyc++;
            if (fifo_err_o) err_seen++;
            if (fifo_data_valid_o && fifo_data_ready_i) begin
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check_val("extra_push", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_val("push_data", fifo_data_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rstn_i = 1'b0; cfg_en_i = 1'b1; cfg_2ch_i = 1'b0; cfg_lsb_first_i = 1'b0;
        cfg_wlen_i = 5'd15; cfg_wnum_i = 3'd0; fifo_data_ready_i = 1'b1;
        i2s_ws_i = 1'b0; i2s_ch0_i = 1'b0; i2s_ch1_i = 1'b0;
        repeat (3) @(posedge sck_i);
        #1;
        check_val("rst_data", fifo_data_o, 32'd0);
        check_val("rst_valid", 32'(fifo_data_valid_o), 32'd0);
        check_val("rst_err", 32'(fifo_err_o), 32'd0);
        rstn_i = 1'b1;

        // 1: mono MSB-first, 16 bits, then ignored bits in the same WS phase
        noise(1'b0, 3);
        tick(1'b1, 1'b0, 1'b0);
        exp_q.push_back(exp_word(32'h0000_A5C3, 15));
        send_word(1'b1, 32'h0000_A5C3, 32'd0);
        noise(1'b1, 20);
        check_val("t1_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("t1_no_err", 32'(err_seen), 32'd0);

        // 2: two channels, LSB-first, 32 bits
        cfg_2ch_i = 1'b1; cfg_lsb_first_i = 1'b1; cfg_wlen_i = 5'd31;
        pop_cyc.delete();
        tick(1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        send_word(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
        noise(1'b0, 6);
        check_val("t2_q_empty", 32'(exp_q.size()), 32'd0);
        if (pop_cyc.size() == 2) check_val("t2_consecutive", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
        else check_val("t2_pop_count", 32'(pop_cyc.size()), 32'd2);

        // 3: TDM, four bytes per phase, then ignored bits
        cfg_2ch_i = 1'b0; cfg_lsb_first_i = 1'b0; cfg_wlen_i = 5'd7; cfg_wnum_i = 3'd3;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(exp_word(32'(i), 7));
            send_word(1'b1, 32'(i), 32'd0);
        end
        noise(1'b1, 12);
        check_val("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // 4: overflow with the FIFO stalled
        cfg_wlen_i = 5'd15; cfg_wnum_i = 3'd1; fifo_data_ready_i = 1'b0;
        err_base = err_seen;
        tick(1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_word(32'h0000_1111, 15));
        send_word(1'b0, 32'h0000_1111, 32'd0);
        send_word(1'b0, 32'h0000_2222, 32'd0);
        noise(1'b0, 4);
        check_val("t4_held_valid", 32'(fifo_data_valid_o), 32'd1);
        check_val("t4_held_data", fifo_data_o, 32'h0000_1111);
        check_val("t4_err_pulse", 32'(err_seen - err_base), 32'd1);
        fifo_data_ready_i = 1'b1;
        noise(1'b0, 5);
        check_val("t4_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("t4_valid_low", 32'(fifo_data_valid_o), 32'd0);

        // 5: WS resync after 5 bits, then a clean word; then disable mid-word
        cfg_wnum_i = 3'd0;
        err_base = err_seen;
        tick(1'b1, 1'b0, 1'b0);
        noise(1'b1, 5);
        tick(1'b0, 1'b0, 1'b0);
        exp_q.push_back(exp_word(32'h0000_3C5A, 15));
        send_word(1'b0, 32'h0000_3C5A, 32'd0);
        noise(1'b0, 4);
        check_val("t5_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("t5_no_err", 32'(err_seen - err_base), 32'd0);
        fifo_data_ready_i = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        send_word(1'b1, 32'h0000_0F0F, 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        check_val("t5_pre_valid", 32'(fifo_data_valid_o), 32'd1);
        check_val("t5_pre_data", fifo_data_o, 32'h0000_0F0F);
        noise(1'b0, 5);
        cfg_en_i = 1'b0;
        tick(1'b0, 1'b1, 1'b0);
        check_val("t5_dis_valid", 32'(fifo_data_valid_o), 32'd0);
        check_val("t5_dis_idle", 32'(dut.state_r), 32'd0);
        fifo_data_ready_i = 1'b1;
        noise(1'b0, 3);

        // 6: word with bit 15 set (sign extension only with the build macro)
        cfg_en_i = 1'b1;
        noise(1'b0, 3);
        tick(1'b1, 1'b0, 1'b0);
`ifdef I2S_RX_SIGN_EXT_EN
        exp_q.push_back(32'hFFFF_8001);
`else
        exp_q.push_back(32'h0000_8001);
`endif
        send_word(1'b1, 32'h0000_8001, 32'd0);
        noise(1'b1, 5);
        check_val("t6_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("total_err_pulses", 32'(err_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
